// File: rtl/frame_scheduler_pkg.sv
// rtl/frame_scheduler_pkg.sv - shared types, widths and defaults for the frame scheduler
package frame_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_TITLE = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_OVER  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    PH_WAIT = 2'd0,
    PH_PHYS = 2'd1,
    PH_COLL = 2'd2,
    PH_SCRL = 2'd3
  } phase_t;

  localparam int Y_W        = 10;
  localparam int SCORE_W    = 16;
  localparam int AMOUNT_W   = 6;
  localparam int WAIT_W     = 10;
  localparam int OVR_W      = 8;
  localparam int OVER_CNT_W = 8;

  localparam int DEF_SCROLL_LINE = 200;
  localparam int DEF_MAX_SCROLL  = 16;
  localparam int DEF_DEATH_Y     = 600;
  localparam int DEF_TIMEOUT     = 1023;
  localparam int DEF_OVER_FRAMES = 120;

  // Rows to scroll so the doodle sits back on the scroll line, clamped per frame.
  function automatic logic [AMOUNT_W-1:0] calc_scroll(
    input logic [Y_W-1:0]      y,
    input logic [Y_W-1:0]      line,
    input logic [AMOUNT_W-1:0] max_rows
  );
    logic [Y_W-1:0] diff;
    diff        = line - y;
    calc_scroll = '0;
    if (y < line) begin
      if (diff > {{(Y_W-AMOUNT_W){1'b0}}, max_rows}) begin
        calc_scroll = max_rows;
      end else begin
        calc_scroll = diff[AMOUNT_W-1:0];
      end
    end
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - game-side handshake and status bundle of the frame scheduler
interface frame_scheduler_if;
  import frame_scheduler_pkg::*;

  logic                switch_frame;
  logic                button_left;
  logic                button_right;
  logic [Y_W-1:0]      doodle_y;
  logic                doodle_done;
  logic                collision_done;
  logic                scroll_ack;
  logic                doodle_step;
  logic                collision_start;
  logic                scroll_valid;
  logic [AMOUNT_W-1:0] scroll_amount;
  logic                game_reset;
  mode_t               mode;
  logic [SCORE_W-1:0]  score;
  logic [OVR_W-1:0]    overrun_count;
  logic                timeout_flag;

  modport master (
    input  switch_frame, button_left, button_right, doodle_y,
           doodle_done, collision_done, scroll_ack,
    output doodle_step, collision_start, scroll_valid, scroll_amount,
           game_reset, mode, score, overrun_count, timeout_flag
  );

  modport slave (
    output switch_frame, button_left, button_right, doodle_y,
           doodle_done, collision_done, scroll_ack,
    input  doodle_step, collision_start, scroll_valid, scroll_amount,
           game_reset, mode, score, overrun_count, timeout_flag
  );

endinterface

// File: rtl/frame_scheduler_edge_detect.sv
// rtl/frame_scheduler_edge_detect.sv - 1-bit edge detector with selectable polarity
module edge_detect #(
  parameter logic FALLING   = 1'b0,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_edge
);

  logic r_q;

  // Previous input level; reset value chosen so an idle line never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VAL;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_edge = FALLING ? (r_q & ~i_d) : (~r_q & i_d);

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame game sequencer: mode, update chain, score, diagnostics
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int SCROLL_LINE = DEF_SCROLL_LINE,
  parameter int MAX_SCROLL  = DEF_MAX_SCROLL,
  parameter int DEATH_Y     = DEF_DEATH_Y,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int OVER_FRAMES = DEF_OVER_FRAMES
) (
  input logic               clk,
  input logic               rst,
  frame_scheduler_if.master io_bus
);

  mode_t               r_mode, w_mode_nxt;
  phase_t              r_phase, w_phase_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic [AMOUNT_W-1:0] r_scroll_amount, w_amount_nxt;
  logic [SCORE_W-1:0]  r_score, w_score_nxt;
  logic [OVR_W-1:0]    r_overrun, w_overrun_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [OVER_CNT_W-1:0] r_over_cnt, w_over_cnt_nxt;
  logic                r_game_reset, w_game_reset_nxt;

  logic                w_tick;
  logic                w_left_rise;
  logic                w_right_rise;
  logic                w_btn_edge;
  logic                w_timed_out;
  logic [SCORE_W:0]    w_score_sum;

  edge_detect #(.FALLING(1'b1), .RESET_VAL(1'b1)) u_vs_edge (
    .clk(clk), .rst(rst), .i_d(io_bus.switch_frame), .o_edge(w_tick)
  );

  edge_detect #(.FALLING(1'b0), .RESET_VAL(1'b0)) u_left_edge (
    .clk(clk), .rst(rst), .i_d(io_bus.button_left), .o_edge(w_left_rise)
  );

  edge_detect #(.FALLING(1'b0), .RESET_VAL(1'b0)) u_right_edge (
    .clk(clk), .rst(rst), .i_d(io_bus.button_right), .o_edge(w_right_rise)
  );

  // Both buttons rising together is a single press.
  assign w_btn_edge  = w_left_rise | w_right_rise;
  assign w_timed_out = (r_wait_cnt == WAIT_W'(TIMEOUT));
  assign w_score_sum = {1'b0, r_score} + {{(SCORE_W+1-AMOUNT_W){1'b0}}, r_scroll_amount};

  // State register for mode, phase, counters and the game_reset pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode          <= MODE_TITLE;
      r_phase         <= PH_WAIT;
      r_wait_cnt      <= '0;
      r_scroll_amount <= '0;
      r_score         <= '0;
      r_overrun       <= '0;
      r_timeout       <= 1'b0;
      r_over_cnt      <= '0;
      r_game_reset    <= 1'b0;
    end else begin
      r_mode          <= w_mode_nxt;
      r_phase         <= w_phase_nxt;
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_scroll_amount <= w_amount_nxt;
      r_score         <= w_score_nxt;
      r_overrun       <= w_overrun_nxt;
      r_timeout       <= w_timeout_nxt;
      r_over_cnt      <= w_over_cnt_nxt;
      r_game_reset    <= w_game_reset_nxt;
    end
  end

  // Next-state logic: phase chain first, then mode-level overrides.
  always_comb begin
    w_mode_nxt       = r_mode;
    w_phase_nxt      = r_phase;
    w_amount_nxt     = r_scroll_amount;
    w_score_nxt      = r_score;
    w_overrun_nxt    = r_overrun;
    w_timeout_nxt    = r_timeout;
    w_over_cnt_nxt   = r_over_cnt;
    w_game_reset_nxt = 1'b0;
    w_wait_cnt_nxt   = (r_phase == PH_WAIT) ? '0 : r_wait_cnt + WAIT_W'(1);

    // A tick seen while the chain is busy is dropped and counted.
    if (w_tick && (r_phase != PH_WAIT) && (r_overrun != '1)) begin
      w_overrun_nxt = r_overrun + OVR_W'(1);
    end

    case (r_phase)
      PH_WAIT: begin
        if (w_tick && (r_mode == MODE_PLAY)) begin
          w_phase_nxt = PH_PHYS;
        end
      end
      PH_PHYS: begin
        if (io_bus.doodle_done) begin
          if (io_bus.doodle_y >= Y_W'(DEATH_Y)) begin
            w_phase_nxt    = PH_WAIT;
            w_mode_nxt     = MODE_OVER;
            w_over_cnt_nxt = '0;
          end else begin
            w_phase_nxt = PH_COLL;
          end
        end else if (w_timed_out) begin
          w_phase_nxt   = PH_WAIT;
          w_timeout_nxt = 1'b1;
        end
      end
      PH_COLL: begin
        if (io_bus.collision_done) begin
          w_phase_nxt  = PH_SCRL;
          w_amount_nxt = calc_scroll(io_bus.doodle_y, Y_W'(SCROLL_LINE),
                                     AMOUNT_W'(MAX_SCROLL));
        end else if (w_timed_out) begin
          w_phase_nxt   = PH_WAIT;
          w_timeout_nxt = 1'b1;
        end
      end
      PH_SCRL: begin
        if (r_scroll_amount == '0) begin
          w_phase_nxt = PH_WAIT;
        end else if (io_bus.scroll_ack) begin
          w_phase_nxt = PH_WAIT;
          w_score_nxt = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        end else if (w_timed_out) begin
          w_phase_nxt   = PH_WAIT;
          w_timeout_nxt = 1'b1;
        end
      end
      default: w_phase_nxt = PH_WAIT;
    endcase

    case (r_mode)
      MODE_TITLE: begin
        w_score_nxt   = '0;
        w_timeout_nxt = 1'b0;
        w_overrun_nxt = '0;
        if (w_btn_edge) begin
          w_mode_nxt       = MODE_PLAY;
          w_game_reset_nxt = 1'b1;
        end
      end
      MODE_OVER: begin
        if (w_tick) begin
          if (r_over_cnt == OVER_CNT_W'(OVER_FRAMES - 1)) begin
            w_mode_nxt     = MODE_TITLE;
            w_over_cnt_nxt = '0;
          end else begin
            w_over_cnt_nxt = r_over_cnt + OVER_CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Every phase starts its wait count from zero.
    if (w_phase_nxt != r_phase) begin
      w_wait_cnt_nxt = '0;
    end
  end

  // Start pulses fire only in the first cycle of their phase.
  assign io_bus.doodle_step     = (r_phase == PH_PHYS) && (r_wait_cnt == '0);
  assign io_bus.collision_start = (r_phase == PH_COLL) && (r_wait_cnt == '0);
  assign io_bus.scroll_valid    = (r_phase == PH_SCRL) && (r_scroll_amount != '0);
  assign io_bus.scroll_amount   = r_scroll_amount;
  assign io_bus.game_reset      = r_game_reset;
  assign io_bus.mode            = r_mode;
  assign io_bus.score           = r_score;
  assign io_bus.overrun_count   = r_overrun;
  assign io_bus.timeout_flag    = r_timeout;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;
  import frame_scheduler_pkg::*;

  typedef struct {
    int y_coll;
    int d_phys;
    int d_coll;
    int d_ack;
    int exp_amount;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_scheduler_if bus();

  frame_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   exp_score = 0;
  int   n_step = 0;
  int   n_coll = 0;
  int   last_amt = 0;
  logic sv_prev = 1'b0;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.switch_frame = 1'b0;
    step();
    bus.switch_frame = 1'b1;
  endtask

  // Scoreboard consumer plus pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.doodle_step) n_step <= n_step + 1;
      if (bus.collision_start) n_coll <= n_coll + 1;
      if (bus.scroll_valid && !sv_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scroll_unexpected: got scroll_valid with amount %0d, expected none",
                   bus.scroll_amount);
        end else begin
          last_amt = exp_q.pop_front();
          check("scroll_amount", 32'(bus.scroll_amount), 32'(last_amt));
        end
      end else if (bus.scroll_valid && sv_prev) begin
        check("scroll_amount_stable", 32'(bus.scroll_amount), 32'(last_amt));
      end
    end
    sv_prev <= bus.scroll_valid;
  end

  task automatic run_vec(input vec_t v);
    int s0;
    s0 = n_step;
    tick();
    check("doodle_step_latency", 32'(bus.doodle_step), 1);
    repeat (v.d_phys) step();
    bus.doodle_y    = 10'd300;
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    check("collision_start", 32'(bus.collision_start), 1);
    repeat (v.d_coll) step();
    bus.doodle_y       = 10'(v.y_coll);
    bus.collision_done = 1'b1;
    if (v.exp_amount != 0) exp_q.push_back(v.exp_amount);
    step();
    bus.collision_done = 1'b0;
    if (v.exp_amount == 0) begin
      check("no_scroll_valid", 32'(bus.scroll_valid), 0);
      step();
    end else begin
      repeat (v.d_ack) step();
      bus.scroll_ack = 1'b1;
      step();
      bus.scroll_ack = 1'b0;
      exp_score += v.exp_amount;
    end
    check("score", 32'(bus.score), 32'(exp_score));
    check("scroll_valid_dropped", 32'(bus.scroll_valid), 0);
    repeat (3) step();
    check("single_doodle_step", 32'(n_step - s0), 1);
  endtask

  initial begin
    int s0;
    int c0;
    vecs[0] = '{y_coll: 190, d_phys: 5, d_coll: 3, d_ack: 2, exp_amount: 10};
    vecs[1] = '{y_coll: 100, d_phys: 1, d_coll: 1, d_ack: 0, exp_amount: 16};
    vecs[2] = '{y_coll: 250, d_phys: 2, d_coll: 2, d_ack: 0, exp_amount: 0};
    vecs[3] = '{y_coll: 199, d_phys: 0, d_coll: 0, d_ack: 1, exp_amount: 1};
    vecs[4] = '{y_coll: 184, d_phys: 3, d_coll: 0, d_ack: 4, exp_amount: 16};
    vecs[5] = '{y_coll: 200, d_phys: 1, d_coll: 1, d_ack: 0, exp_amount: 0};

    bus.switch_frame   = 1'b1;
    bus.button_left    = 1'b0;
    bus.button_right   = 1'b0;
    bus.doodle_y       = 10'd300;
    bus.doodle_done    = 1'b0;
    bus.collision_done = 1'b0;
    bus.scroll_ack     = 1'b0;

    rst = 1'b1;
    repeat (2) step();
    check("rst_mode", 32'(bus.mode), 0);
    check("rst_score", 32'(bus.score), 0);
    check("rst_overrun", 32'(bus.overrun_count), 0);
    check("rst_timeout", 32'(bus.timeout_flag), 0);
    check("rst_strobes", 32'({bus.doodle_step, bus.collision_start, bus.scroll_valid, bus.game_reset}), 0);
    check("rst_amount", 32'(bus.scroll_amount), 0);
    rst = 1'b0;
    step();

    // Title: a tick does nothing, a button press starts the game.
    tick();
    step();
    check("title_no_step", 32'(n_step), 0);
    bus.button_left = 1'b1;
    step();
    check("game_reset_pulse", 32'(bus.game_reset), 1);
    check("mode_play", 32'(bus.mode), 1);
    check("play_score", 32'(bus.score), 0);
    step();
    check("game_reset_one_cycle", 32'(bus.game_reset), 0);
    bus.button_left = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    // Physics never answers: the chain times out and the next tick restarts it.
    c0 = n_coll;
    tick();
    repeat (1000) step();
    check("timeout_not_yet", 32'(bus.timeout_flag), 0);
    repeat (30) step();
    check("timeout_flag", 32'(bus.timeout_flag), 1);
    check("timeout_no_coll", 32'(n_coll - c0), 0);
    check("timeout_score", 32'(bus.score), 32'(exp_score));
    tick();
    check("restart_after_timeout", 32'(bus.doodle_step), 1);
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    bus.doodle_y       = 10'd250;
    bus.collision_done = 1'b1;
    step();
    bus.collision_done = 1'b0;
    repeat (3) step();
    check("timeout_sticky", 32'(bus.timeout_flag), 1);

    // Second vsync while collision is pending is an overrun, not a new chain.
    s0 = n_step;
    tick();
    bus.doodle_y    = 10'd300;
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    step();
    tick();
    check("overrun_one", 32'(bus.overrun_count), 1);
    step();
    bus.doodle_y       = 10'd250;
    bus.collision_done = 1'b1;
    step();
    bus.collision_done = 1'b0;
    repeat (3) step();
    check("overrun_no_extra_step", 32'(n_step - s0), 1);

    // Tick in the very cycle the chain finishes still counts as an overrun.
    s0 = n_step;
    tick();
    bus.doodle_y    = 10'd300;
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    bus.doodle_y       = 10'd190;
    bus.collision_done = 1'b1;
    exp_q.push_back(10);
    step();
    bus.collision_done = 1'b0;
    bus.scroll_ack   = 1'b1;
    bus.switch_frame = 1'b0;
    step();
    bus.scroll_ack   = 1'b0;
    bus.switch_frame = 1'b1;
    exp_score += 10;
    check("ack_score", 32'(bus.score), 32'(exp_score));
    check("overrun_at_return", 32'(bus.overrun_count), 2);
    repeat (3) step();
    check("no_step_after_overrun", 32'(n_step - s0), 1);

    // Death: chain aborts, mode OVER, buttons ignored, back to TITLE after 120 ticks.
    c0 = n_coll;
    tick();
    bus.doodle_y    = 10'd600;
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    check("death_no_coll", 32'(bus.collision_start), 0);
    check("mode_over", 32'(bus.mode), 2);
    check("over_score_kept", 32'(bus.score), 32'(exp_score));
    bus.button_right = 1'b1;
    step();
    check("over_button_mode", 32'(bus.mode), 2);
    check("over_button_no_reset", 32'(bus.game_reset), 0);
    bus.button_right = 1'b0;
    step();
    for (int i = 0; i < 119; i++) begin
      tick();
      step();
    end
    check("over_before_last", 32'(bus.mode), 2);
    tick();
    check("back_to_title", 32'(bus.mode), 0);
    step();
    check("title_score_clr", 32'(bus.score), 0);
    check("title_overrun_clr", 32'(bus.overrun_count), 0);
    check("title_timeout_clr", 32'(bus.timeout_flag), 0);
    check("death_coll_count", 32'(n_coll - c0), 0);
    exp_score = 0;

    // Reset in the middle of a chain returns everything to reset values.
    bus.button_left  = 1'b1;
    bus.button_right = 1'b1;
    step();
    check("both_buttons_play", 32'(bus.mode), 1);
    bus.button_left  = 1'b0;
    bus.button_right = 1'b0;
    step();
    run_vec(vecs[0]);
    tick();
    bus.doodle_y    = 10'd300;
    bus.doodle_done = 1'b1;
    step();
    bus.doodle_done = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_mode", 32'(bus.mode), 0);
    check("midrst_score", 32'(bus.score), 0);
    check("midrst_amount", 32'(bus.scroll_amount), 0);
    check("midrst_strobes", 32'({bus.doodle_step, bus.collision_start, bus.scroll_valid, bus.game_reset}), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
